turbo_deintlv_ctrl: RTL

TURBO_DEINTLV_CTRL -- requirements
Module: turbo_deintlv_ctrl

---
 rtl/turbo_deintlv_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/turbo_deintlv_ctrl.sv
// turbo_deintlv_ctrl: row-write / column-read block deinterleaver controller over an external symbol RAM
module turbo_deintlv_ctrl #(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] cfg_rows,
  input  logic [A_WIDTH-1:0] cfg_cols,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               ram_wen,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic [D_WIDTH-1:0] ram_wdata,
  output logic               ram_ren,
  output logic [A_WIDTH-1:0] ram_raddr,
  input  logic [D_WIDTH-1:0] ram_rdata,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DRAIN = 2'd3;
  localparam logic [2*A_WIDTH-1:0] CAP = (2*A_WIDTH)'(1) << A_WIDTH;
  logic [1:0] st;
  logic [A_WIDTH-1:0] r_q, c_q, wcnt, row, col, raddr;
  logic [A_WIDTH:0] n_q;
  logic [2*A_WIDTH-1:0] prod;
  logic cfg_ok, w_last, row_end, r_last, rv;
  // config validation on the full-width product, and frame-end detection
  always_comb begin
    prod = {{A_WIDTH{1'b0}}, cfg_rows} * {{A_WIDTH{1'b0}}, cfg_cols};
    cfg_ok = cfg_rows != '0 && cfg_cols != '0 && prod <= CAP;
    w_last = {1'b0, wcnt} == n_q - 1'b1;
    row_end = row == r_q - 1'b1;
    r_last = row_end && col == c_q - 1'b1;
  end
  // RAM ports and stream outputs; addresses and data are forced to 0 when not enabled
  always_comb begin
    in_ready = st == WRITE;
    ram_wen = in_ready && in_valid;
    ram_waddr = ram_wen ? wcnt : '0;
    ram_wdata = ram_wen ? in_data : '0;
    ram_ren = st == READ;
    ram_raddr = ram_ren ? raddr : '0;
    out_valid = rv;
    out_data = rv ? ram_rdata : '0;
    out_last = st == DRAIN;
    done = st == DRAIN;
    busy = st != IDLE;
  end
  // frame FSM; the read address steps by C down a column and restarts at the next column index
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      r_q <= '0;
      c_q <= '0;
      n_q <= '0;
      wcnt <= '0;
      row <= '0;
      col <= '0;
      raddr <= '0;
      rv <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      rv <= st == READ;
      case (st)
        IDLE: if (start) begin
          if (cfg_ok) begin
            r_q <= cfg_rows;
            c_q <= cfg_cols;
            n_q <= prod[A_WIDTH:0];
            wcnt <= '0;
            row <= '0;
            col <= '0;
            raddr <= '0;
            st <= WRITE;
          end else cfg_err <= 1'b1;
        end
        WRITE: if (in_valid) begin
          wcnt <= wcnt + 1'b1;
          if (w_last) st <= READ;
        end
        READ: begin
          if (r_last) st <= DRAIN;
          else if (row_end) begin
            row <= '0;
            col <= col + 1'b1;
            raddr <= col + 1'b1;
          end else begin
            row <= row + 1'b1;
            raddr <= raddr + c_q;
          end
        end
        DRAIN: st <= IDLE;
      endcase
    end
  end
endmodule
